// File: rtl/vga_exp_pkg.sv
// ============================================================================
// Package : vga_exp_pkg
// Shared types and constants for the sdram_vga_exp pattern generator/checker.
// VGA_CHK_FULL16_EN widens the checked pattern from 10 to 16 bits.
// Revision: 1.0
// ============================================================================
`default_nettype none

package vga_exp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef VGA_CHK_FULL16_EN
    localparam int CHK_W = 16;
`else
    localparam int CHK_W = 10;
`endif

    localparam int DEF_DATA_DEPTH = 1024 * 768;
    localparam int DEF_SPAN_NUM   = 9;

endpackage

`default_nettype wire

// File: rtl/vga_pat_cmp.sv
// ============================================================================
// Module  : vga_pat_cmp
// Combinational expected-value generator and comparator for one pixel word.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_pat_cmp
    import vga_exp_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic [CHK_W-1:0] i_init,
    input  logic [CNT_W-1:0] i_idx,
    input  logic [CHK_W-1:0] i_data,
    output logic             o_mismatch
);

    logic [CHK_W-1:0] w_expected;

    // Sum is taken at CHK_W bits so the pattern wraps at 2**CHK_W.
    assign w_expected = i_init + CHK_W'(i_idx);
    assign o_mismatch = (i_data != w_expected);

endmodule

`default_nettype wire

// File: rtl/vga_data_chk.sv
// ============================================================================
// Module  : vga_data_chk
// Drains one frame of pixel words and checks them against the incrementing
// generator pattern. Build with VGA_CHK_FULL16_EN to compare all 16 bits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_data_chk
    import vga_exp_pkg::*;
#(
    parameter int DATA_DEPTH = DEF_DATA_DEPTH,
    parameter int SPAN_NUM   = DEF_SPAN_NUM,
    parameter int CNT_W      = $clog2(DATA_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             rd_rdy,
    output logic             rd_req,
    input  logic [15:0]      din,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [15:0]      frame_cnt
);

    state_t             r_state;
    state_t             w_state_nx;
    logic               r_start_d;
    logic [CNT_W-1:0]   r_idx;
    logic [CHK_W-1:0]   r_init;
    logic               r_err;
    logic [15:0]        r_err_cnt;
    logic [CNT_W-1:0]   r_first_idx;
    logic [15:0]        r_frame_cnt;

    logic               w_start_pe;
    logic               w_xfer;
    logic               w_last;
    logic               w_mismatch;

`ifndef VGA_CHK_FULL16_EN
    logic               w_unused_din;
    assign w_unused_din = ^din[15:CHK_W];
`endif

    assign w_start_pe = start_i & ~r_start_d;
    assign w_xfer     = (r_state == RUN) && rd_rdy;
    assign w_last     = (r_idx == CNT_W'(DATA_DEPTH - 1));

    vga_pat_cmp #(
        .CNT_W      (CNT_W)
    ) u_pat_cmp (
        .i_init     (r_init),
        .i_idx      (r_idx),
        .i_data     (din[CHK_W-1:0]),
        .o_mismatch (w_mismatch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        rd_req     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_pe) begin
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                rd_req = 1'b1;
                busy   = 1'b1;
                if (rd_rdy && w_last) begin
                    w_state_nx = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_d   <= 1'b0;
            r_idx       <= '0;
            r_init      <= '0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
            r_first_idx <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_start_d <= start_i;
            if ((r_state == IDLE) && w_start_pe) begin
                r_idx       <= '0;
                r_err       <= 1'b0;
                r_err_cnt   <= '0;
                r_first_idx <= '0;
            end
            if (w_xfer) begin
                // Index returns to zero after the last word so it stays in range.
                r_idx <= w_last ? '0 : r_idx + CNT_W'(1);
                if (w_mismatch) begin
                    r_err <= 1'b1;
                    if (r_err_cnt != 16'hFFFF) begin
                        r_err_cnt <= r_err_cnt + 16'd1;
                    end
                    if (!r_err) begin
                        r_first_idx <= r_idx;
                    end
                end
            end
            if (r_state == DONE) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_init      <= r_init + CHK_W'(SPAN_NUM);
            end
        end
    end

    assign err           = r_err;
    assign err_cnt       = r_err_cnt;
    assign first_err_idx = r_first_idx;
    assign frame_cnt     = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_vga_data_chk.sv
// ============================================================================
// Module  : tb_vga_data_chk
// Scoreboard bench for vga_data_chk with DATA_DEPTH=16, SPAN_NUM=9.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_data_chk;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          rd_rdy = 1'b0;
    logic          rd_req;
    logic [15:0]   din = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic [15:0]   err_cnt;
    logic [CW-1:0] first_err_idx;
    logic [15:0]   frame_cnt;

    vga_data_chk #(
        .DATA_DEPTH    (DEPTH),
        .SPAN_NUM      (9)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .rd_rdy        (rd_rdy),
        .rd_req        (rd_req),
        .din           (din),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nx;
        int err;
        int cnt;
        int first;
        int fc;
    } exp_t;

    exp_t        q[$];
    logic [15:0] words[DEPTH];
    int          n_total = 0;
    int          n_pass  = 0;
    int          mon_x   = 0;
    logic        prev_done = 1'b0;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    endtask

    task automatic fill(input int base);
        for (int i = 0; i < DEPTH; i++) words[i] = 16'(base + i);
    endtask

    task automatic push_exp(input int e, input int c, input int f, input int fc);
        exp_t x;
        x.nx = DEPTH; x.err = e; x.cnt = c; x.first = f; x.fc = fc;
        q.push_back(x);
    endtask

    // Monitor: counts transfers and checks frame results on each done pulse.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            mon_x     = 0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("xfer_count", mon_x, e.nx);
                    chk("err", err, e.err);
                    chk("err_cnt", err_cnt, e.cnt);
                    chk("first_err_idx", first_err_idx, e.first);
                    chk("frame_cnt_at_done", frame_cnt, e.fc);
                    chk("rd_req_at_done", rd_req, 0);
                end
                if (prev_done) chk("done_width", 1, 0);
                mon_x = 0;
            end else if (rd_req && rd_rdy) begin
                mon_x++;
            end
            prev_done = done;
        end
    end

    // Drives one frame: start held for `hold` cycles, optional extra start
    // pulse, rd_rdy pattern on/off, optional reset when word rst_at is offered.
    task automatic feed(input int hold, input int pulse_at, input int on_len,
                        input int off_len, input int rst_at, input bit chk_clr);
        int  ptr = 0;
        bit  fin = 0;
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            @(negedge clk);
            start_i = (cyc < hold) || (cyc == pulse_at);
            rd_rdy  = (off_len == 0) ? 1'b1 : ((cyc % (on_len + off_len)) < on_len);
            din     = words[(ptr < DEPTH) ? ptr : DEPTH - 1];
            if (rst_at >= 0 && ptr == rst_at && busy) begin
                rst_n = 1'b0;
                #1;
                chk("rst_rd_req", rd_req, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_err", err, 0);
                chk("rst_err_cnt", err_cnt, 0);
                chk("rst_first_idx", first_err_idx, 0);
                chk("rst_frame_cnt", frame_cnt, 0);
                @(negedge clk);
                rst_n = 1'b1;
                fin = 1;
            end else begin
                #1;
                if (chk_clr && cyc == 2) begin
                    chk("clr_err", err, 0);
                    chk("clr_err_cnt", err_cnt, 0);
                    chk("clr_first_idx", first_err_idx, 0);
                end
                if (rd_req && rd_rdy) ptr++;
                if (done) fin = 1;
            end
        end
        if (!fin) chk("frame_timeout", 0, 1);
        start_i = 1'b0;
        rd_rdy  = 1'b0;
    endtask

    initial begin
        #3;
        chk("reset_rd_req", rd_req, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_err_cnt", err_cnt, 0);
        chk("reset_first_idx", first_err_idx, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Frame 1: start value 0, continuous rd_rdy.
        fill(0);
        push_exp(0, 0, 0, 0);
        feed(1, -1, 1, 0, -1, 0);
        @(negedge clk); #1;
        chk("f1_frame_cnt", frame_cnt, 1);
        chk("f1_rd_req_idle", rd_req, 0);

        // Frame 2: start value 9, rd_rdy 5 on / 15 off.
        fill(9);
        push_exp(0, 0, 0, 1);
        feed(1, -1, 5, 15, -1, 0);
        @(negedge clk); #1;
        chk("f2_frame_cnt", frame_cnt, 2);

        // Frame 3: start value 18, words 5 and 9 corrupted.
        fill(18);
        words[5] = 16'h03FF;
        words[9] = 16'h0000;
        push_exp(1, 2, 5, 2);
        feed(1, -1, 1, 0, -1, 0);
        @(negedge clk); #1;
        chk("f3_err_hold", err, 1);
        chk("f3_frame_cnt", frame_cnt, 3);

        // Frame 4: start held 3 cycles, extra edge mid-frame, new start clears.
        fill(27);
        push_exp(0, 0, 0, 3);
        feed(3, 10, 1, 0, -1, 1);
        repeat (5) @(negedge clk);
        #1;
        chk("f4_busy_after", busy, 0);
        chk("f4_frame_cnt", frame_cnt, 4);

        // Frame 5: reset while word 7 is offered; no done expected.
        fill(36);
        feed(1, -1, 1, 0, 7, 0);
        repeat (2) @(negedge clk);

        // Frame 6: pattern restarts at 0; bit 15 set on word 3.
        fill(0);
        words[3] = 16'h8003;
`ifdef VGA_CHK_FULL16_EN
        push_exp(1, 1, 3, 0);
`else
        push_exp(0, 0, 0, 0);
`endif
        feed(1, -1, 1, 0, -1, 0);
        @(negedge clk); #1;
        chk("f6_frame_cnt", frame_cnt, 1);

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_data_chk.md
Name: vga_data_chk

Overview:
Consumer-side counterpart of vga_data_gen in the sdram_vga_exp design. It drains one frame of DATA_DEPTH pixel words from the memory read port using a ready/request handshake. It checks each word against the generator's incrementing pattern, where each new frame's start value advances by SPAN_NUM. It reports frame completion, a sticky error flag, an error count and the index of the first mismatch, for board self-test and for simulation.

Parameters:
DATA_DEPTH, 1024*768, words per frame (>=2)
SPAN_NUM, 9, increment of the frame start value between consecutive frames
CNT_W, $clog2(DATA_DEPTH), width of the word index

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start_i  input  1  frame start request; rising edge starts a frame (level may stay high several cycles)
rd_rdy  input  1  memory read side has a valid word on din
rd_req  output  1  checker accepts a word; transfer when rd_req && rd_rdy
din  input  16  pixel word from memory, valid when rd_rdy=1
busy  output  1  high while a frame is being consumed
done  output  1  one-cycle pulse after the last word of a frame
err  output  1  sticky mismatch flag for the current/last frame
err_cnt  output  16  mismatches in current/last frame, saturating at 16'hFFFF
first_err_idx  output  CNT_W  word index of first mismatch in the frame
frame_cnt  output  16  completed frames since reset, wraps

Behaviour:
- Reset (async, rst_n=0): state IDLE; rd_req=0, busy=0, done=0, err=0, err_cnt=0, first_err_idx=0, frame_cnt=0, init_value=0, word index=0, start edge register=0. Reset mid-frame aborts the frame with no done pulse.
- Edge detect: start_d registers start_i. start_pe = start_i & ~start_d.
- FSM IDLE: on start_pe go to RUN. Same edge: index=0, err=0, err_cnt=0, first_err_idx=0.
- FSM RUN: rd_req=1 and busy=1, both decoded from state with no extra latency.
  - Per transfer: expected = (init_value + index) mod 1024. Compare din[9:0] against expected.
  - On mismatch: err<=1, err_cnt increments with saturation. If err was 0 before this transfer, first_err_idx<=index.
  - index increments on each transfer.
  - rd_rdy=0 stalls: no state change.
  - Transfer with index==DATA_DEPTH-1: go to DONE. rd_req is 0 from the next cycle, so exactly DATA_DEPTH words are consumed.
- FSM DONE (one cycle): done=1, busy=0, frame_cnt+=1, init_value<=(init_value+SPAN_NUM) mod 1024. Then go to IDLE.
- start_pe in RUN or DONE is ignored; it is not queued. A level still high on return to IDLE does not restart, because only edges start a frame.
- err, err_cnt and first_err_idx hold their values after done until the next start.
- Arithmetic: expected is computed in 10 bits and wraps modulo 1024. index is CNT_W bits and never exceeds DATA_DEPTH-1.

Optional Feature:
VGA_CHK_FULL16_EN
- Defined: compare all 16 bits of din against (init_value + index) mod 65536; init_value is kept 16 bits wide.
- Undefined: only din[9:0] is compared, and din[15:10] is ignored.

Decomposition:
- Shared package vga_exp_pkg holds:
  - FSM state enum: IDLE, RUN, DONE
  - CHK_W constant: 10, or 16 when the macro is defined
  - Default DATA_DEPTH and SPAN_NUM constants, also used by vga_data_gen
- One natural sub-module: vga_pat_cmp, a combinational expected-value and compare unit with inputs init_value and index and output mismatch. The FSM and counters stay in the top.

Test Plan:
- DATA_DEPTH=16, SPAN_NUM=9, rd_rdy=1 continuously, din=0..15, start pulse:
  - 16 transfers, rd_req low from the cycle after the last transfer
  - done pulses once, err=0, frame_cnt=1
- Second frame, din=9..24 with rd_rdy toggled 5 on / 15 off:
  - stalls respected, exactly 16 transfers, err=0, frame_cnt=2
  - a third frame expects start value 18
- Frame where word 5 is 0x3FF and word 9 is corrupted -> err=1, err_cnt=2, first_err_idx=5. A new start clears all three.
- start_i held high for 3 cycles, plus an extra rising edge mid-frame -> only one frame consumed, frame_cnt +1.
- rst_n asserted at word 7 -> all outputs are at reset values immediately, no done pulse. The next start expects values from 0.
- Build with VGA_CHK_FULL16_EN and din[15]=1 on word 3 -> err_cnt=1. Without the macro, the same stimulus gives err=0.
